fpga_irq_responder: RTL and testbench
=====================================

# fpga_irq_responder

FPGA-side interrupt responder on the HPS lightweight bridge: the HPS is the Avalon-MM initiator; this block is the slave end. It synchronises N_SRC asynchronous event lines from fabric logic, latches edges or levels into a pending register, drives a single IRQ line toward the HPS interrupt controller, and lets software read, mask and clear pending events through a 4-register map.

## Interface
- N_SRC, 8, number of event sources (1..32); register bits at and above N_SRC read 0, and writes to them are ignored.
- SYNC_STAGES, 2, synchroniser depth per source (2..4).
- clk  in  1  single clock domain for all logic.
- reset  in  1  synchronous, active-high; sampled on rising clk.
- src  in  N_SRC  asynchronous event inputs.
- avs_address  in  2  word address.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  read data, fixed read latency 1.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_writebyteenable_n  in  4  active-low byte enables; byte k is written iff bit k == 0.
- irq  out  1  registered interrupt request to HPS, active-high level.

## Operation
- Register map:
  - 0 PENDING: read = pending bits; write-1-to-clear per enabled byte.
  - 1 MASK: RW; irq source enable.
  - 2 MODE: RW; per bit, 0 = rising-edge capture, 1 = level (pending set while synchronised input is high).
  - 3 COUNT: event counter, see Configuration.
- Per source: SYNC_STAGES flop chain, then a prev flop. rise = sync & ~prev.
- Set condition per bit: MODE ? sync : rise. Pending is set when the set condition is true. Pending is cleared by a W1C write.
- Same-cycle set and W1C on the same bit: set wins; no event is lost.
- A level-mode bit cleared while its input is still high re-sets on the next cycle.
- irq <= |(pending & mask), registered.
- Masked sources still latch pending; unmasking a pending bit raises irq one cycle later.
- Simultaneous avs_read and avs_write: both are performed. Readdata reflects pre-write register contents.
- Address 3 with COUNT compiled out: reads 0, writes ignored.

## Timing
- Reset values: pending = 0, mask = 0, mode = 0, count = 0, sync/prev chains = 0, irq = 0, avs_readdata = 0.
- An input already high when reset is released is seen as a rising edge. This is intentional: no event is dropped across a reset.
- Source-to-irq latency: with src rising before edge 1, pending is set at edge SYNC_STAGES+1 and irq rises at edge SYNC_STAGES+2. With defaults this is 4 cycles.
- Read: avs_read sampled at edge t drives avs_readdata valid after edge t. avs_readdata is 0 in cycles with no read the previous cycle. No waitrequest.
- Write: takes effect at the sampling edge. After a W1C of the last unmasked pending bit, irq falls one edge later.
- Reset asserted mid-operation clears all state at the next edge, regardless of bus activity in that cycle.

## Configuration
- FPGA_IRQ_RESP_COUNT_EN
  - Defined: COUNT is a 16-bit saturating counter of cycles in which at least one set condition fires. It saturates at 0xFFFF and reads zero-extended to 32 bits. Any write to address 3 with byte 0 or byte 1 enabled clears it; an increment in the same cycle is dropped.
  - Undefined: no counter logic; address 3 reads 0.

## Structure
- Package fpga_irq_resp_pkg holds:
  - Address constants ADDR_PENDING = 0, ADDR_MASK = 1, ADDR_MODE = 2, ADDR_COUNT = 3.
  - A byte-mask function expanding avs_writebyteenable_n into a 32-bit active-high bit mask.
  - The COUNT width constant (16).
- One sub-module, irq_src_sync: the per-source synchroniser chain, prev flop and set-condition output; instantiated N_SRC times.
- Top level holds the register file, bus decode, optional counter and irq flop.

## Test plan
- Reset, then read all 4 addresses: all return 0 and irq = 0.
- Write MASK = 0x01, pulse src[0] for 1 cycle (held long enough to be synchronised): PENDING reads 0x01 and irq rises exactly 4 edges after src rises. Write 0x01 to PENDING with avs_writebyteenable_n = 0x0: irq falls 1 edge later.
- Write MASK = 0xFF with avs_writebyteenable_n = 0xE: only byte 0 is written. Write MASK = 0xFF00 with avs_writebyteenable_n = 0xD: MASK still reads 0xFF, because bits at and above N_SRC = 8 are ignored.
- Set MODE bit 2, hold src[2] high, W1C bit 2: PENDING bit 2 reads 1 again on the next read. Rising src[3] in the same cycle as a W1C of bit 3: bit 3 stays set.
- With FPGA_IRQ_RESP_COUNT_EN defined: force 0x10005 events, COUNT reads 0x0000FFFF. Write to address 3: reads 0. Without the macro: COUNT always reads 0.
- Assert reset with irq high and pending = 0xA5: after 1 edge all registers read 0 and irq = 0. Hold src[1] high through reset release: PENDING bit 1 sets.

Source files
------------

// File: rtl/fpga_irq_resp_pkg.sv
// Shared constants and helpers for the FPGA interrupt responder.
// Latency: none (package only).
// Backpressure: none (package only).
package fpga_irq_resp_pkg;

  localparam int ADDR_W  = 2;
  localparam int COUNT_W = 16;

  localparam logic [ADDR_W-1:0] ADDR_PENDING = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_MASK    = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_MODE    = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_COUNT   = 2'd3;

  // Expand active-low byte enables into an active-high 32-bit bit mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] be_n);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) begin
      m[8*k +: 8] = {8{~be_n[k]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/fpga_irq_responder_if.sv
// Avalon-MM slave bus between the HPS lightweight bridge and the responder.
// Latency: reads return one cycle after the read strobe; writes act on the sampling edge.
// Backpressure: none, there is no waitrequest.
interface fpga_irq_responder_if;
  import fpga_irq_resp_pkg::*;

  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic [31:0]       avs_readdata;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_writebyteenable_n;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_writebyteenable_n,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_writebyteenable_n,
    output avs_readdata
  );

endinterface

// File: rtl/fpga_irq_responder_irq_src_sync.sv
// Per-source synchroniser chain, edge-detect flop and set-condition output.
// Latency: set_cond asserts SYNC_STAGES edges after src rises.
// Backpressure: none; free-running sampler.
module irq_src_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic mode,
  output logic set_cond
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  // Shift the async input through the chain; prev holds the last synchronised value.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src};
      prev_q <= sync;
    end
  end

  // Level mode fires while high; edge mode fires on the first high cycle only.
  always_comb begin
    set_cond = mode ? sync : (sync & ~prev_q);
  end

endmodule

// File: rtl/fpga_irq_responder.sv
// HPS-facing interrupt responder: syncs event lines, latches pending, drives irq, exposes 4 regs.
// Latency: src to irq SYNC_STAGES+2 edges; read data one cycle after read strobe.
// Backpressure: none; the bus never stalls. Optional counter: FPGA_IRQ_RESP_COUNT_EN.
module fpga_irq_responder
  import fpga_irq_resp_pkg::*;
#(
  parameter int N_SRC       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SRC-1:0]     src,
  fpga_irq_responder_if.slave  bus,
  output logic                 irq
);

  logic [N_SRC-1:0] set_cond;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] mode;
  logic [31:0]      readdata;
  logic [31:0]      rd_mux;

  // Write data already gated by the byte enables; bits at and above N_SRC are dropped.
  logic [31:0]      wr_bits;
  logic [N_SRC-1:0] wr_src;
  logic [N_SRC-1:0] bm_src;
  logic [31:0]      bm_full;
  logic             unused_wr;

  assign bm_full   = byte_mask(bus.avs_writebyteenable_n);
  assign wr_bits   = bus.avs_writedata & bm_full;
  assign wr_src    = wr_bits[N_SRC-1:0];
  assign bm_src    = bm_full[N_SRC-1:0];
  assign unused_wr = ^wr_bits;

  logic wr_pending;
  logic wr_mask;
  logic wr_mode;

  assign wr_pending = bus.avs_write && (bus.avs_address == ADDR_PENDING);
  assign wr_mask    = bus.avs_write && (bus.avs_address == ADDR_MASK);
  assign wr_mode    = bus.avs_write && (bus.avs_address == ADDR_MODE);

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    irq_src_sync #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clk      (clk),
      .reset    (reset),
      .src      (src[i]),
      .mode     (mode[i]),
      .set_cond (set_cond[i])
    );
  end

  // Pending latch: a new set condition beats a same-cycle W1C so no event is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else if (wr_pending) begin
      pending <= (pending & ~wr_src) | set_cond;
    end else begin
      pending <= pending | set_cond;
    end
  end

  // MASK and MODE: plain RW with per-byte write enables.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask <= '0;
      mode <= '0;
    end else begin
      if (wr_mask) mask <= (mask & ~bm_src) | wr_src;
      if (wr_mode) mode <= (mode & ~bm_src) | wr_src;
    end
  end

  // Registered interrupt request from unmasked pending bits.
  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= |(pending & mask);
  end

`ifdef FPGA_IRQ_RESP_COUNT_EN
  logic [COUNT_W-1:0] count;
  logic               count_clr;

  assign count_clr = bus.avs_write && (bus.avs_address == ADDR_COUNT) &&
                     (!bus.avs_writebyteenable_n[0] || !bus.avs_writebyteenable_n[1]);

  // Saturating count of cycles with any set condition; a clear drops a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (count_clr) begin
      count <= '0;
    end else if ((|set_cond) && (count != {COUNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end
`endif

  // Read mux over pre-write register contents.
  always_comb begin
    rd_mux = '0;
    case (bus.avs_address)
      ADDR_PENDING: rd_mux[N_SRC-1:0] = pending;
      ADDR_MASK:    rd_mux[N_SRC-1:0] = mask;
      ADDR_MODE:    rd_mux[N_SRC-1:0] = mode;
`ifdef FPGA_IRQ_RESP_COUNT_EN
      ADDR_COUNT:   rd_mux[COUNT_W-1:0] = count;
`else
      ADDR_COUNT:   rd_mux = '0;
`endif
      default:      rd_mux = '0;
    endcase
  end

  // Read data register: valid the cycle after a read, zero otherwise.
  always_ff @(posedge clk) begin
    if (reset)             readdata <= '0;
    else if (bus.avs_read) readdata <= rd_mux;
    else                   readdata <= '0;
  end

  assign bus.avs_readdata = readdata;

endmodule

// File: tb/tb_fpga_irq_responder.sv
// Directed bench for fpga_irq_responder with hand-computed expectations.
// Latency: checks irq timing edge by edge after src changes.
// Backpressure: none on the bus; every access completes in one cycle.
module tb_fpga_irq_responder;
  import fpga_irq_resp_pkg::*;

  logic       clk;
  logic       reset;
  logic [7:0] src;
  logic       irq;

  int tests_run;
  int tests_failed;

  fpga_irq_responder_if bus();

  fpga_irq_responder #(
    .N_SRC       (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .src   (src),
    .bus   (bus),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All bus tasks start and end on a falling edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] ben);
    bus.avs_address           = a;
    bus.avs_writedata         = d;
    bus.avs_writebyteenable_n = ben;
    bus.avs_write             = 1'b1;
    @(negedge clk);
    bus.avs_write             = 1'b0;
    bus.avs_writebyteenable_n = 4'hF;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    @(negedge clk);
    d            = bus.avs_readdata;
    bus.avs_read = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_irq: got %b expected 0", irq);
    end
    tests_run++;
    if (bus.avs_readdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_readdata: got %h expected 0", bus.avs_readdata);
    end
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      tests_run++;
      if (rd !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_read_addr%0d: got %h expected 0", a, rd);
      end
    end
  endtask

  task automatic test_irq_latency();
    logic [31:0] rd;
    logic        exp_irq;
    bus_write(ADDR_MASK, 32'h1, 4'h0);
    src[0] = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      exp_irq = (e == 4);
      tests_run++;
      if (irq !== exp_irq) begin
        tests_failed++;
        $display("FAIL irq_latency_edge%0d: got %b expected %b", e, irq, exp_irq);
      end
      if (e == 2) src[0] = 1'b0;
    end
    bus_read(ADDR_PENDING, rd);
    tests_run++;
    if (rd !== 32'h1) begin
      tests_failed++;
      $display("FAIL pending_src0: got %h expected 1", rd);
    end
    bus_write(ADDR_PENDING, 32'h1, 4'h0);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_at_w1c_edge: got %b expected 1", irq);
    end
    @(negedge clk);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_after_w1c: got %b expected 0", irq);
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd;
    bus_write(ADDR_MASK, 32'h0000_00FF, 4'hE);
    bus_read(ADDR_MASK, rd);
    tests_run++;
    if (rd !== 32'hFF) begin
      tests_failed++;
      $display("FAIL mask_byte0: got %h expected ff", rd);
    end
    bus_write(ADDR_MASK, 32'h0000_FF00, 4'hD);
    bus_read(ADDR_MASK, rd);
    tests_run++;
    if (rd !== 32'hFF) begin
      tests_failed++;
      $display("FAIL mask_high_bits_ignored: got %h expected ff", rd);
    end
    bus_write(ADDR_MASK, 32'h0000_0000, 4'h1);
    bus_read(ADDR_MASK, rd);
    tests_run++;
    if (rd !== 32'hFF) begin
      tests_failed++;
      $display("FAIL mask_byte0_disabled: got %h expected ff", rd);
    end
    bus_write(ADDR_MASK, 32'h0000_005A, 4'hE);
    bus_read(ADDR_MASK, rd);
    tests_run++;
    if (rd !== 32'h5A) begin
      tests_failed++;
      $display("FAIL mask_rewrite: got %h expected 5a", rd);
    end
  endtask

  task automatic test_level_mode();
    logic [31:0] rd;
    bus_write(ADDR_MODE, 32'h4, 4'h0);
    bus_write(ADDR_MASK, 32'hFF, 4'h0);
    bus_read(ADDR_MODE, rd);
    tests_run++;
    if (rd !== 32'h4) begin
      tests_failed++;
      $display("FAIL mode_readback: got %h expected 4", rd);
    end
    src[2] = 1'b1;
    repeat (4) @(negedge clk);
    bus_read(ADDR_PENDING, rd);
    tests_run++;
    if (rd !== 32'h4) begin
      tests_failed++;
      $display("FAIL level_pending: got %h expected 4", rd);
    end
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL level_irq: got %b expected 1", irq);
    end
    bus_write(ADDR_PENDING, 32'h4, 4'h0);
    bus_read(ADDR_PENDING, rd);
    tests_run++;
    if (rd !== 32'h4) begin
      tests_failed++;
      $display("FAIL level_reset_after_w1c: got %h expected 4", rd);
    end
    src[2] = 1'b0;
    repeat (4) @(negedge clk);
    bus_write(ADDR_PENDING, 32'h4, 4'h0);
    bus_read(ADDR_PENDING, rd);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL level_cleared_low: got %h expected 0", rd);
    end
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL level_irq_low: got %b expected 0", irq);
    end
    bus_write(ADDR_MODE, 32'h0, 4'h0);
  endtask

  task automatic test_set_beats_clear();
    logic [31:0] rd;
    src[3] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus_write(ADDR_PENDING, 32'h8, 4'h0);
    bus_read(ADDR_PENDING, rd);
    tests_run++;
    if (rd !== 32'h8) begin
      tests_failed++;
      $display("FAIL set_beats_w1c: got %h expected 8", rd);
    end
    src[3] = 1'b0;
    repeat (3) @(negedge clk);
    bus_write(ADDR_PENDING, 32'h8, 4'h0);
    bus_read(ADDR_PENDING, rd);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL edge_w1c_clear: got %h expected 0", rd);
    end
  endtask

  task automatic test_read_write_same_cycle();
    logic [31:0] rd;
    bus.avs_address           = ADDR_MASK;
    bus.avs_writedata         = 32'h0F;
    bus.avs_writebyteenable_n = 4'h0;
    bus.avs_read              = 1'b1;
    bus.avs_write             = 1'b1;
    @(negedge clk);
    rd                        = bus.avs_readdata;
    bus.avs_read              = 1'b0;
    bus.avs_write             = 1'b0;
    bus.avs_writebyteenable_n = 4'hF;
    tests_run++;
    if (rd !== 32'hFF) begin
      tests_failed++;
      $display("FAIL rw_prewrite_data: got %h expected ff", rd);
    end
    bus_read(ADDR_MASK, rd);
    tests_run++;
    if (rd !== 32'h0F) begin
      tests_failed++;
      $display("FAIL rw_write_done: got %h expected 0f", rd);
    end
    @(negedge clk);
    tests_run++;
    if (bus.avs_readdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL readdata_idle: got %h expected 0", bus.avs_readdata);
    end
    bus_write(ADDR_MASK, 32'hFF, 4'h0);
  endtask

  task automatic test_count();
    logic [31:0] rd;
`ifdef FPGA_IRQ_RESP_COUNT_EN
    bus_write(ADDR_MODE, 32'h1, 4'h0);
    src[0] = 1'b1;
    repeat (32'h10005) @(negedge clk);
    bus_read(ADDR_COUNT, rd);
    tests_run++;
    if (rd !== 32'h0000_FFFF) begin
      tests_failed++;
      $display("FAIL count_saturate: got %h expected 0000ffff", rd);
    end
    src[0] = 1'b0;
    repeat (4) @(negedge clk);
    bus_write(ADDR_COUNT, 32'h0, 4'hE);
    bus_read(ADDR_COUNT, rd);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL count_clear: got %h expected 0", rd);
    end
    bus_write(ADDR_MODE, 32'h0, 4'h0);
`else
    src[0] = 1'b1;
    repeat (4) @(negedge clk);
    src[0] = 1'b0;
    bus_read(ADDR_COUNT, rd);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL count_absent_read: got %h expected 0", rd);
    end
    bus_write(ADDR_COUNT, 32'hFFFF_FFFF, 4'h0);
    bus_read(ADDR_COUNT, rd);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL count_absent_write: got %h expected 0", rd);
    end
`endif
    repeat (4) @(negedge clk);
    bus_write(ADDR_PENDING, 32'hFF, 4'h0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    src = 8'hA5;
    repeat (4) @(negedge clk);
    src = 8'h00;
    bus_read(ADDR_PENDING, rd);
    tests_run++;
    if (rd !== 32'hA5) begin
      tests_failed++;
      $display("FAIL pending_a5: got %h expected a5", rd);
    end
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_before_reset: got %b expected 1", irq);
    end
    reset                     = 1'b1;
    bus.avs_address           = ADDR_MASK;
    bus.avs_writedata         = 32'hFF;
    bus.avs_writebyteenable_n = 4'h0;
    bus.avs_write             = 1'b1;
    bus.avs_read              = 1'b1;
    @(negedge clk);
    bus.avs_write             = 1'b0;
    bus.avs_read              = 1'b0;
    bus.avs_writebyteenable_n = 4'hF;
    reset                     = 1'b0;
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_after_reset: got %b expected 0", irq);
    end
    tests_run++;
    if (bus.avs_readdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL readdata_after_reset: got %h expected 0", bus.avs_readdata);
    end
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      tests_run++;
      if (rd !== 32'h0) begin
        tests_failed++;
        $display("FAIL midreset_read_addr%0d: got %h expected 0", a, rd);
      end
    end
  endtask

  task automatic test_src_through_reset();
    logic [31:0] rd;
    src[1] = 1'b1;
    reset  = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    bus_read(ADDR_PENDING, rd);
    tests_run++;
    if (rd !== 32'h2) begin
      tests_failed++;
      $display("FAIL src_high_at_release: got %h expected 2", rd);
    end
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL masked_irq: got %b expected 0", irq);
    end
    bus_write(ADDR_MASK, 32'h2, 4'h0);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL unmask_same_edge: got %b expected 0", irq);
    end
    @(negedge clk);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL unmask_irq: got %b expected 1", irq);
    end
    src[1] = 1'b0;
  endtask

  initial begin
    tests_run                 = 0;
    tests_failed              = 0;
    reset                     = 1'b1;
    src                       = '0;
    bus.avs_address           = '0;
    bus.avs_read              = 1'b0;
    bus.avs_write             = 1'b0;
    bus.avs_writedata         = '0;
    bus.avs_writebyteenable_n = 4'hF;

    test_reset();
    test_irq_latency();
    test_byte_enable();
    test_level_mode();
    test_set_beats_clear();
    test_read_write_same_cycle();
    test_count();
    test_reset_mid();
    test_src_through_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
